// File: rtl/mips_datapath.sv
// mips_datapath: single-cycle MIPS32 execution datapath (data side).
// Holds a 32x32 register file, an immediate extender, an ALU/shifter and a
// word-addressed data RAM. One instruction completes per clock.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rs, rt, rd            register addresses (read A, read B / alt write, write)
//   shamt, immediate      instruction shift amount and 16-bit immediate
//   sign1, sign2          sign-extend immediate / signed SLT
//   RegDst, RegWrite      write address select, register write enable
//   ALUsrc, ALUcontrol    operand B select, ALU operation
//   MemWrite, MemRead     data RAM write / read enables
//   MemtoReg              writeback select (ALU result or RAM data)
//   oe, shift             output enable for out, shifter select
//   out                   writeback data when oe, else 0
//   beq                   zero flag of the ALU result
//   extend                extended immediate
module mips_datapath #(
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] immediate,
  input  logic        sign1,
  input  logic        sign2,
  input  logic        RegDst,
  input  logic        RegWrite,
  input  logic        ALUsrc,
  input  logic [2:0]  ALUcontrol,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        MemtoReg,
  input  logic        oe,
  input  logic        shift,
  output logic [31:0] out,
  output logic        beq,
  output logic [31:0] extend
);

  localparam int unsigned AW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SLT = 3'b110,
    ALU_LUI = 3'b111
  } alu_op_e;

  logic [31:0]   regs_q [32];
  logic [31:0]   dmem_q [DMEM_DEPTH];

  logic [31:0]   rs_data;
  logic [31:0]   rt_data;
  logic [31:0]   alu_b;
  logic [31:0]   alu_result;
  logic          slt;
  logic [AW-1:0] dmem_idx;
  logic [31:0]   mem_rdata;
  logic [31:0]   wb_data;
  logic [4:0]    wr_addr;

  assign rs_data = (rs == 5'd0) ? '0 : regs_q[rs];
  assign rt_data = (rt == 5'd0) ? '0 : regs_q[rt];

  assign extend = sign1 ? {{16{immediate[15]}}, immediate} : {16'h0000, immediate};
  assign alu_b  = ALUsrc ? extend : rt_data;
  assign slt    = sign2 ? ($signed(rs_data) < $signed(alu_b)) : (rs_data < alu_b);

  always_comb begin
    alu_result = '0;
    if (shift) begin
      // Shifts operate on R[rt] directly, independent of ALUsrc.
      case (ALUcontrol)
        3'b000:  alu_result = rt_data << shamt;
        3'b001:  alu_result = rt_data >> shamt;
        3'b010:  alu_result = $unsigned($signed(rt_data) >>> shamt);
        default: alu_result = '0;
      endcase
    end else begin
      case (alu_op_e'(ALUcontrol))
        ALU_ADD: alu_result = rs_data + alu_b;
        ALU_SUB: alu_result = rs_data - alu_b;
        ALU_AND: alu_result = rs_data & alu_b;
        ALU_OR:  alu_result = rs_data | alu_b;
        ALU_XOR: alu_result = rs_data ^ alu_b;
        ALU_NOR: alu_result = ~(rs_data | alu_b);
        ALU_SLT: alu_result = {31'b0, slt};
        ALU_LUI: alu_result = alu_b << 16;
        default: alu_result = '0;
      endcase
    end
  end

  assign beq = (alu_result == '0);

  // Byte offset dropped; upper bits discarded so the address wraps.
  assign dmem_idx  = alu_result[AW+1:2];
  assign mem_rdata = MemRead ? dmem_q[dmem_idx] : '0;

  assign wb_data = MemtoReg ? mem_rdata : alu_result;
  assign wr_addr = RegDst ? rd : rt;
  assign out     = oe ? wb_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (RegWrite && (wr_addr != 5'd0)) begin
      regs_q[wr_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
        dmem_q[i] <= '0;
      end
    end else if (MemWrite) begin
      dmem_q[dmem_idx] <= rt_data;
    end
  end

endmodule

// File: tb/tb_mips_datapath.sv
// Scoreboard bench for mips_datapath: stimulus pushes hand-computed
// expectations, a monitor pops and compares them on the falling edge.
module tb_mips_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic        sign1, sign2, RegDst, RegWrite, ALUsrc;
  logic [2:0]  ALUcontrol;
  logic        MemWrite, MemRead, MemtoReg, oe, shift;
  logic [31:0] out;
  logic        beq;
  logic [31:0] extend;

  int checks   = 0;
  int failures = 0;

  typedef enum int {K_OUT, K_BEQ, K_EXT} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  mips_datapath #(.DMEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .immediate(immediate), .sign1(sign1), .sign2(sign2), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUcontrol(ALUcontrol),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemtoReg(MemtoReg), .oe(oe),
    .shift(shift), .out(out), .beq(beq), .extend(extend)
  );

  always #5 clk = ~clk;

  // Monitor: compares every pending expectation against the settled outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_OUT:   act = out;
        K_BEQ:   act = {31'b0, beq};
        default: act = extend;
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic push_exp(input string n, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    reset = 1'b0; rs = '0; rt = '0; rd = '0; shamt = '0; immediate = '0;
    sign1 = 1'b0; sign2 = 1'b0; RegDst = 1'b0; RegWrite = 1'b0; ALUsrc = 1'b0;
    ALUcontrol = 3'b000; MemWrite = 1'b0; MemRead = 1'b0; MemtoReg = 1'b0;
    oe = 1'b1; shift = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // R[r] + 0 through the ALU, no writes.
  task automatic read_reg(input string n, input logic [4:0] r, input logic [31:0] v);
    idle();
    rs = r; ALUsrc = 1'b1;
    push_exp(n, K_OUT, v);
    step();
  endtask

  // R[dst] = sign-extended imm via ADD from R0.
  task automatic load_imm(input string n, input logic [4:0] dst, input logic [15:0] imm,
                          input logic [31:0] v);
    idle();
    rt = dst; immediate = imm; ALUsrc = 1'b1; sign1 = 1'b1; RegWrite = 1'b1;
    push_exp(n, K_OUT, v);
    step();
  endtask

  // Register-register ALU op with A=R[a], B=R[b].
  task automatic alu_rr(input string n, input logic [2:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic s2, input logic [31:0] v);
    idle();
    rs = a; rt = b; ALUcontrol = op; sign2 = s2;
    push_exp(n, K_OUT, v);
    step();
  endtask

  task automatic shift_op(input string n, input logic [2:0] op, input logic [4:0] src,
                          input logic [4:0] amt, input logic [31:0] v);
    idle();
    shift = 1'b1; rt = src; shamt = amt; ALUcontrol = op;
    push_exp(n, K_OUT, v);
    step();
  endtask

  task automatic load_word(input string n, input logic [15:0] addr, input logic [31:0] v);
    idle();
    immediate = addr; ALUsrc = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1;
    push_exp(n, K_OUT, v);
    step();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();

    // Reset state.
    read_reg("rst_r2", 5'd2, 32'd0);
    idle();
    push_exp("rst_out", K_OUT, 32'd0);
    push_exp("rst_beq", K_BEQ, 32'd1);
    push_exp("rst_ext", K_EXT, 32'd0);
    step();

    // Immediate loads and register-register add.
    load_imm("addi_r2", 5'd2, 16'd10, 32'd10);
    read_reg("r2_eq10", 5'd2, 32'd10);
    load_imm("addi_r3", 5'd3, 16'd5, 32'd5);
    idle();
    rs = 5'd2; rt = 5'd3; rd = 5'd4; RegDst = 1'b1; RegWrite = 1'b1;
    push_exp("add_r4", K_OUT, 32'd15);
    step();
    read_reg("r4_eq15", 5'd4, 32'd15);

    // Immediate extension.
    idle();
    immediate = 16'hFFFF; sign1 = 1'b1;
    push_exp("ext_sign", K_EXT, 32'hFFFF_FFFF);
    step();
    idle();
    immediate = 16'hFFFF; sign1 = 1'b0;
    push_exp("ext_zero", K_EXT, 32'h0000_FFFF);
    step();

    // SUB and zero flag.
    idle();
    rs = 5'd2; immediate = 16'd10; ALUsrc = 1'b1; sign1 = 1'b1; ALUcontrol = 3'b001;
    push_exp("sub_beq1", K_BEQ, 32'd1);
    push_exp("sub_out0", K_OUT, 32'd0);
    step();
    idle();
    rs = 5'd2; immediate = 16'd5; ALUsrc = 1'b1; sign1 = 1'b1; ALUcontrol = 3'b001;
    push_exp("sub_beq0", K_BEQ, 32'd0);
    push_exp("sub_out5", K_OUT, 32'd5);
    step();

    // Logic ops with R2=10, R3=5.
    alu_rr("and", 3'b010, 5'd2, 5'd3, 1'b0, 32'd0);
    alu_rr("or",  3'b011, 5'd2, 5'd3, 1'b0, 32'd15);
    alu_rr("xor", 3'b100, 5'd2, 5'd3, 1'b0, 32'd15);
    alu_rr("nor", 3'b101, 5'd2, 5'd3, 1'b0, 32'hFFFF_FFF0);
    alu_rr("slt_10_5", 3'b110, 5'd2, 5'd3, 1'b0, 32'd0);
    alu_rr("slt_5_10", 3'b110, 5'd3, 5'd2, 1'b0, 32'd1);

    idle();
    immediate = 16'h1234; ALUsrc = 1'b1; ALUcontrol = 3'b111;
    push_exp("lui", K_OUT, 32'h1234_0000);
    step();

    // Signed vs unsigned SLT with R5 = -1.
    load_imm("addi_r5", 5'd5, 16'hFFFF, 32'hFFFF_FFFF);
    alu_rr("slt_signed",   3'b110, 5'd5, 5'd2, 1'b1, 32'd1);
    alu_rr("slt_unsigned", 3'b110, 5'd5, 5'd2, 1'b0, 32'd0);

    // Shifter.
    shift_op("sll", 3'b000, 5'd2, 5'd2, 32'd40);
    shift_op("srl", 3'b001, 5'd2, 5'd2, 32'd2);
    shift_op("sra_neg", 3'b010, 5'd5, 5'd4, 32'hFFFF_FFFF);
    shift_op("srl_neg", 3'b001, 5'd5, 5'd4, 32'h0FFF_FFFF);
    shift_op("shift_bad", 3'b011, 5'd2, 5'd1, 32'd0);

    // ADD wraps.
    idle();
    rs = 5'd5; immediate = 16'd1; ALUsrc = 1'b1; sign1 = 1'b1;
    push_exp("add_wrap", K_OUT, 32'd0);
    push_exp("add_wrap_beq", K_BEQ, 32'd1);
    step();

    // SW R4 to addr 8; same-cycle read returns old word (0).
    idle();
    rt = 5'd4; immediate = 16'd8; ALUsrc = 1'b1; MemWrite = 1'b1;
    MemRead = 1'b1; MemtoReg = 1'b1;
    push_exp("sw_rd_old", K_OUT, 32'd0);
    step();

    // LW into R6.
    idle();
    rt = 5'd6; immediate = 16'd8; ALUsrc = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1;
    RegWrite = 1'b1;
    push_exp("lw", K_OUT, 32'd15);
    step();
    read_reg("r6_eq15", 5'd6, 32'd15);
    load_word("lw_wrap", 16'h0408, 32'd15);
    load_word("lw_byteoff", 16'h000B, 32'd15);
    idle();
    immediate = 16'd8; ALUsrc = 1'b1; MemtoReg = 1'b1;
    push_exp("lw_noread", K_OUT, 32'd0);
    step();

    // Same-cycle read of register being written sees old value.
    idle();
    rs = 5'd2; rt = 5'd2; immediate = 16'd7; ALUsrc = 1'b1; RegWrite = 1'b1;
    push_exp("rdw_old", K_OUT, 32'd17);
    step();
    read_reg("r2_eq17", 5'd2, 32'd17);

    // R0 is hardwired to zero.
    load_imm("wr_r0", 5'd0, 16'd99, 32'd99);
    alu_rr("r0_zero", 3'b011, 5'd0, 5'd0, 1'b0, 32'd0);

    // oe gates out but not beq.
    idle();
    rs = 5'd2; oe = 1'b0;
    push_exp("oe_off", K_OUT, 32'd0);
    push_exp("oe_off_beq", K_BEQ, 32'd0);
    step();

    // Mid-run reset with a suppressed write.
    idle();
    reset = 1'b1; rt = 5'd7; immediate = 16'd55; ALUsrc = 1'b1; RegWrite = 1'b1;
    MemWrite = 1'b1;
    step();
    read_reg("rst2_r2", 5'd2, 32'd0);
    read_reg("rst2_r4", 5'd4, 32'd0);
    read_reg("rst2_r7", 5'd7, 32'd0);
    load_word("rst2_mem", 16'd8, 32'd0);
    load_word("rst2_mem55", 16'd55, 32'd0);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
